// File: rtl/if_prefetch_unit_if.sv
// if_prefetch_unit_if: imem request/response, redirect and instruction-output signals of the prefetch unit
interface if_prefetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic            imem_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_data;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: in-order instruction prefetch queue with redirect flush; IFQ_BYPASS_EN adds same-cycle response bypass
module if_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              PC_STEP  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                clr,
    if_prefetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL = PW'(DEPTH);

    logic            run_q;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [PW-1:0]   alloc_q, alloc_d, fill_q, fill_d, rd_q, rd_d;
    logic [PW-1:0]   inflight_q, inflight_d, drop_q, drop_d;
    logic [XLEN-1:0] pc_q [DEPTH];
    logic [31:0]     ins_q [DEPTH];
    logic [PW-1:0]   occ;
    logic            accept, resp_keep, stored, pop;

    assign occ       = alloc_q - rd_q;
    assign stored    = rd_q != fill_q;
    assign resp_keep = bus.imem_rvalid && drop_q == '0;
    assign accept    = bus.imem_req && bus.imem_ready;
    assign pop       = bus.inst_valid && bus.inst_ready;

    // run_q holds requests off until the first edge after reset release
    assign bus.imem_req  = run_q && !bus.redirect_valid && occ < FULL && inflight_q < FULL;
    assign bus.imem_addr = fpc_q;
    assign bus.inst_pc   = pc_q[rd_q[AW-1:0]];
`ifdef IFQ_BYPASS_EN
    assign bus.inst_valid = (stored || resp_keep) && !bus.redirect_valid;
    assign bus.inst_data  = (!stored && resp_keep) ? bus.imem_rdata : ins_q[rd_q[AW-1:0]];
`else
    assign bus.inst_valid = stored && !bus.redirect_valid;
    assign bus.inst_data  = ins_q[rd_q[AW-1:0]];
`endif

    // next-state of fetch PC, queue pointers and response counters
    always_comb begin
        fpc_d      = fpc_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        rd_d       = rd_q;
        inflight_d = inflight_q + PW'(accept) - PW'(bus.imem_rvalid);
        drop_d     = drop_q - PW'(bus.imem_rvalid && drop_q != '0);
        if (bus.redirect_valid) begin
            fpc_d   = bus.redirect_pc;
            fill_d  = alloc_q;
            rd_d    = alloc_q;
            // inflight already counts responses marked for dropping, so it alone is the owed total
            drop_d  = inflight_q - PW'(bus.imem_rvalid);
        end else begin
            alloc_d = accept ? alloc_q + 1'b1 : alloc_q;
            fpc_d   = accept ? fpc_q + XLEN'(PC_STEP) : fpc_q;
            fill_d  = resp_keep ? fill_q + 1'b1 : fill_q;
            rd_d    = pop ? rd_q + 1'b1 : rd_q;
        end
    end

    // control state registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            run_q      <= 1'b0;
            fpc_q      <= RESET_PC;
            alloc_q    <= '0;
            fill_q     <= '0;
            rd_q       <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            run_q      <= 1'b1;
            fpc_q      <= fpc_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            rd_q       <= rd_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // queue storage: PC written at request accept, instruction at response fill
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                ins_q[i] <= '0;
            end
        end else begin
            if (accept)
                pc_q[alloc_q[AW-1:0]] <= fpc_q;
            if (resp_keep && !bus.redirect_valid)
                ins_q[fill_q[AW-1:0]] <= bus.imem_rdata;
        end
    end
endmodule
